// File: rtl/mem_rsp_demux.sv
// Return-path router for the shared I/D memory port.
// In-order tag FIFO steers each read word to the fetch or MEM response register.
module mem_rsp_demux #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_fire,
  input  logic                     req_src,
  output logic                     req_ready,
  input  logic                     rsp_valid,
  input  logic [DW-1:0]            rsp_data,
  output logic                     rsp_ready,
  output logic                     i_valid,
  output logic [DW-1:0]            i_data,
  input  logic                     i_ready,
  output logic                     d_valid,
  output logic [DW-1:0]            d_data,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_unexpected
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_tag;
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic [AW:0]      r_cnt;
  logic             r_iv;
  logic             r_dv;
  logic [DW-1:0]    r_id;
  logic [DW-1:0]    r_dd;
  logic             r_err;

  logic w_empty;
  logic w_full;
  logic w_head;
  logic w_ifree;
  logic w_dfree;
  logic w_push;
  logic w_acc;
  logic w_pop;
  logic w_ild;
  logic w_dld;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_head  = r_tag[r_rp[AW-1:0]];
  assign w_ifree = !r_iv || i_ready;
  assign w_dfree = !r_dv || d_ready;

  // Ready depends only on registered state and the stage readies.
  assign req_ready = !w_full;
  assign rsp_ready = w_empty ? 1'b1 : (w_head ? w_ifree : w_dfree);

  assign w_push = req_fire && !w_full;
  assign w_acc  = rsp_valid && rsp_ready;
  assign w_pop  = w_acc && !w_empty;
  assign w_ild  = w_pop && w_head;
  assign w_dld  = w_pop && !w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wp[AW-1:0]] <= req_src;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Reload wins over drain so back-to-back words stream at full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iv <= 1'b0;
      r_dv <= 1'b0;
      r_id <= '0;
      r_dd <= '0;
    end else begin
      if (w_ild) begin
        r_iv <= 1'b1;
        r_id <= rsp_data;
      end else if (i_ready) begin
        r_iv <= 1'b0;
      end
      if (w_dld) begin
        r_dv <= 1'b1;
        r_dd <= rsp_data;
      end else if (d_ready) begin
        r_dv <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_acc && w_empty) begin
      r_err <= 1'b1;
    end
  end

  assign i_valid        = r_iv;
  assign i_data         = r_id;
  assign d_valid        = r_dv;
  assign d_data         = r_dd;
  assign outstanding    = r_cnt;
  assign err_unexpected = r_err;

endmodule

// File: tb/tb_mem_rsp_demux.sv
// Bench for mem_rsp_demux: directed scenarios with literal expectations
// plus randomized traffic against a queue-based reference model.
module tb_mem_rsp_demux;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          req_fire;
  logic          req_src;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_ready;
  logic          d_valid;
  logic [DW-1:0] d_data;
  logic          d_ready;
  logic [2:0]    outstanding;
  logic          err_unexpected;

  int errors = 0;
  int checks = 0;

  mem_rsp_demux #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_fire(req_fire), .req_src(req_src), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .d_valid(d_valid), .d_data(d_data), .d_ready(d_ready),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of pending sources and the two output registers.
  bit            mq[$];
  bit            m_iv;
  bit            m_dv;
  logic [DW-1:0] m_id;
  logic [DW-1:0] m_dd;
  bit            m_err;
  bit            cmp_en = 1'b0;

  task automatic chk(input string n, input logic [DW-1:0] a,
                     input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_iv = 0; m_dv = 0; m_id = '0; m_dd = '0; m_err = 0;
  endtask

  function automatic bit exp_rsp_ready();
    if (mq.size() == 0) return 1'b1;
    if (mq[0]) return !m_iv || i_ready;
    return !m_dv || d_ready;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      int  sz;
      bit  acc;
      bit  h;
      bit  li;
      bit  ld;
      sz  = mq.size();
      acc = rsp_valid && exp_rsp_ready();
      li  = 0;
      ld  = 0;
      if (acc) begin
        if (sz == 0) m_err = 1;
        else begin
          h = mq.pop_front();
          if (h) begin m_id = rsp_data; li = 1; end
          else   begin m_dd = rsp_data; ld = 1; end
        end
      end
      if (li) m_iv = 1; else if (i_ready) m_iv = 0;
      if (ld) m_dv = 1; else if (d_ready) m_dv = 0;
      if (req_fire && sz < DEPTH) mq.push_back(req_src);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("req_ready", DW'(req_ready), DW'(mq.size() < DEPTH));
      chk("rsp_ready", DW'(rsp_ready), DW'(exp_rsp_ready()));
      chk("i_valid", DW'(i_valid), DW'(m_iv));
      chk("d_valid", DW'(d_valid), DW'(m_dv));
      chk("i_data", i_data, m_id);
      chk("d_data", d_data, m_dd);
      chk("outstanding", DW'(outstanding), DW'(mq.size()));
      chk("err_unexpected", DW'(err_unexpected), DW'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_fire = 0; req_src = 0; rsp_valid = 0; rsp_data = '0;
  endtask

  initial begin
    idle();
    i_ready = 1; d_ready = 1;
    rst_n = 0;
    model_reset();
    tick(); tick();
    chk("rst outstanding", DW'(outstanding), 0);
    chk("rst req_ready", DW'(req_ready), 1);
    chk("rst rsp_ready", DW'(rsp_ready), 1);
    chk("rst valids", DW'({i_valid, d_valid}), 0);
    chk("rst data", i_data | d_data, 0);
    chk("rst err", DW'(err_unexpected), 0);
    rst_n = 1;
    cmp_en = 1;

    // Three requests, then three in-order responses.
    req_fire = 1; req_src = 1; tick();
    req_src = 0; tick();
    req_src = 1; tick();
    idle();
    chk("three outstanding", DW'(outstanding), 3);
    rsp_valid = 1; rsp_data = 32'h11; tick();
    chk("first i_data", i_data, 32'h11);
    chk("first i_valid", DW'(i_valid), 1);
    rsp_data = 32'h22; tick();
    chk("second d_data", d_data, 32'h22);
    chk("second d_valid", DW'(d_valid), 1);
    rsp_data = 32'h33; tick();
    chk("third i_data", i_data, 32'h33);
    chk("drained outstanding", DW'(outstanding), 0);
    idle(); tick();

    // Stray response with nothing outstanding.
    rsp_valid = 1; rsp_data = 32'hDEAD; #1;
    chk("stray rsp_ready", DW'(rsp_ready), 1);
    tick();
    idle();
    chk("stray err", DW'(err_unexpected), 1);
    chk("stray valids", DW'({i_valid, d_valid}), 0);
    chk("stray d_data kept", d_data, 32'h22);

    // Data-side back-pressure.
    req_fire = 1; req_src = 0; tick(); tick();
    idle();
    d_ready = 0;
    rsp_valid = 1; rsp_data = 32'hA1; tick();
    rsp_data = 32'hA2; #1;
    chk("stall rsp_ready", DW'(rsp_ready), 0);
    tick();
    chk("stall d_data", d_data, 32'hA1);
    d_ready = 1; #1;
    chk("release rsp_ready", DW'(rsp_ready), 1);
    tick();
    idle();
    chk("reload d_valid", DW'(d_valid), 1);
    chk("reload d_data", d_data, 32'hA2);
    tick();

    // Head-of-line: fetch side blocked, data side free.
    req_fire = 1; req_src = 1; tick(); tick();
    req_src = 0; tick();
    idle();
    i_ready = 0;
    rsp_valid = 1; rsp_data = 32'hB1; tick();
    rsp_data = 32'hB2; #1;
    chk("hol rsp_ready", DW'(rsp_ready), 0);
    tick();
    chk("hol d_valid", DW'(d_valid), 0);
    chk("hol i_data", i_data, 32'hB1);
    i_ready = 1; tick(); tick();
    idle();
    chk("hol order d_data", d_data, 32'hB2);
    tick();

    // Fill, ignored overflow push, then pop and push+pop.
    req_fire = 1;
    for (int k = 0; k < DEPTH; k++) begin
      req_src = k[0]; tick();
    end
    chk("full outstanding", DW'(outstanding), DEPTH);
    chk("full req_ready", DW'(req_ready), 0);
    req_src = 1; tick();
    chk("overflow ignored", DW'(outstanding), DEPTH);
    req_fire = 0; rsp_valid = 1; rsp_data = 32'hC0; tick();
    chk("pop outstanding", DW'(outstanding), DEPTH - 1);
    chk("pop req_ready", DW'(req_ready), 1);
    chk("pop dest d_data", d_data, 32'hC0);
    req_fire = 1; req_src = 0; rsp_data = 32'hC1; tick();
    chk("push+pop outstanding", DW'(outstanding), DEPTH - 1);
    chk("push+pop i_data", i_data, 32'hC1);
    req_fire = 0;
    repeat (DEPTH) begin
      rsp_data = $urandom; tick();
    end
    idle();
    chk("refill drained", DW'(outstanding), 0);

    // Asynchronous reset with requests pending.
    req_fire = 1; req_src = 1; tick(); tick();
    idle();
    rsp_valid = 1; rsp_data = 32'hE1; tick();
    rsp_valid = 0;
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("async rst outstanding", DW'(outstanding), 0);
    chk("async rst valids", DW'({i_valid, d_valid}), 0);
    chk("async rst err", DW'(err_unexpected), 0);
    tick();
    rst_n = 1;
    rsp_valid = 1; rsp_data = 32'hE2; tick();
    idle();
    chk("late rsp err", DW'(err_unexpected), 1);
    chk("late rsp i_valid", DW'(i_valid), 0);

    // Randomized traffic.
    rst_n = 0; model_reset(); tick(); rst_n = 1;
    for (int c = 0; c < 2000; c++) begin
      bit full_now;
      full_now  = (mq.size() >= DEPTH);
      req_fire  = full_now ? ($urandom_range(15) == 0) : $urandom_range(1);
      req_src   = $urandom_range(1);
      rsp_valid = (mq.size() == 0) ? ($urandom_range(15) == 0)
                                   : ($urandom_range(3) != 0);
      rsp_data  = $urandom;
      i_ready   = ($urandom_range(3) != 0);
      d_ready   = ($urandom_range(3) != 0);
      tick();
    end
    idle();
    i_ready = 1; d_ready = 1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
